// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: single-cycle ALU, iterative shift-add MUL, flush handling
module ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_id,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  input  logic [DATA_W-1:0] st_data,
  input  logic [3:0]        alu_op,
  input  logic              mem_rd_id,
  input  logic              mem_wr_id,
  input  logic              MemtoReg_id,
  input  logic              RegWrite_id,
  input  logic              Branch_id,
  input  logic [REG_AW-1:0] towrite_id,
  input  logic [1:0]        load_byte_id,
  input  logic              store_byte_id,
  input  logic              flush,
  output logic              stall_out,
  output logic [DATA_W-1:0] addr,
  output logic [DATA_W-1:0] din,
  output logic              cs,
  output logic              oe,
  output logic              we,
  output logic              MemtoReg_ex,
  output logic              RegWrite_ex,
  output logic              Branch_ex,
  output logic [REG_AW-1:0] towrite_ex,
  output logic [1:0]        load_byte,
  output logic              store_byte_in
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              cs;
    logic              oe;
    logic              we;
    logic              m2r;
    logic              rw;
    logic              br;
    logic [REG_AW-1:0] tw;
    logic [1:0]        lb;
    logic              sb;
  } out_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] mcand, mcand_n, mplier, mplier_n, acc, acc_n;
  out_t              lat, lat_n, out_q, out_n, incoming;
  logic [DATA_W-1:0] alu_res, sum;
  logic [SH_W-1:0]   shamt;
  logic              is_mul;

  assign shamt  = opB[SH_W-1:0];
  assign is_mul = valid_id && (alu_op == 4'd13);

  always_comb begin
    alu_res = opA + opB;
    case (alu_op)
      4'd1:  alu_res = opA - opB;
      4'd2:  alu_res = opA & opB;
      4'd3:  alu_res = opA | opB;
      4'd4:  alu_res = opA ^ opB;
      4'd5:  alu_res = opA << shamt;
      4'd6:  alu_res = opA >> shamt;
      4'd7:  alu_res = $signed(opA) >>> shamt;
      4'd8:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(opA) < $signed(opB))};
      4'd9:  alu_res = {{(DATA_W-1){1'b0}}, (opA < opB)};
      4'd10: alu_res = {{(DATA_W-1){1'b0}}, (opA == opB)};
      4'd11: alu_res = {{(DATA_W-1){1'b0}}, (opA != opB)};
      4'd12: alu_res = opB << (DATA_W / 2);
      default: alu_res = opA + opB;
    endcase
  end

  // r0 is never a writeback target, so its RegWrite is dropped here
  always_comb begin
    incoming      = '0;
    incoming.addr = alu_res;
    incoming.din  = st_data;
    incoming.cs   = mem_rd_id | mem_wr_id;
    incoming.oe   = mem_rd_id;
    incoming.we   = mem_wr_id;
    incoming.m2r  = MemtoReg_id;
    incoming.rw   = RegWrite_id & (towrite_id != '0);
    incoming.br   = Branch_id;
    incoming.tw   = towrite_id;
    incoming.lb   = load_byte_id;
    incoming.sb   = store_byte_id;
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    mcand_n  = mcand;
    mplier_n = mplier;
    acc_n    = acc;
    lat_n    = lat;
    out_n    = '0;
    sum      = acc + (mplier[0] ? mcand : '0);
    if (flush) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mul) begin
            state_n  = MUL_BUSY;
            lat_n    = incoming;
            mcand_n  = opA;
            mplier_n = opB;
            acc_n    = '0;
            cnt_n    = '0;
          end else if (valid_id) begin
            out_n = incoming;
          end
        end
        MUL_BUSY: begin
          acc_n    = sum;
          mcand_n  = mcand << 1;
          mplier_n = mplier >> 1;
          cnt_n    = cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            out_n      = lat;
            out_n.addr = sum;
            state_n    = IDLE;
            cnt_n      = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign stall_out = ~reset & ~flush &
                     (((state == IDLE) & is_mul) | ((state == MUL_BUSY) & (cnt != CNT_LAST)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      lat    <= '0;
      out_q  <= '0;
    end else begin
      cnt    <= cnt_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      acc    <= acc_n;
      lat    <= lat_n;
      out_q  <= out_n;
    end
  end

  assign addr          = out_q.addr;
  assign din           = out_q.din;
  assign cs            = out_q.cs;
  assign oe            = out_q.oe;
  assign we            = out_q.we;
  assign MemtoReg_ex   = out_q.m2r;
  assign RegWrite_ex   = out_q.rw;
  assign Branch_ex     = out_q.br;
  assign towrite_ex    = out_q.tw;
  assign load_byte     = out_q.lb;
  assign store_byte_in = out_q.sb;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_id;
  logic [31:0] opA, opB, st_data;
  logic [3:0]  alu_op;
  logic        mem_rd_id, mem_wr_id, MemtoReg_id, RegWrite_id, Branch_id;
  logic [4:0]  towrite_id;
  logic [1:0]  load_byte_id;
  logic        store_byte_id, flush;
  logic        stall_out;
  logic [31:0] addr, din;
  logic        cs, oe, we, MemtoReg_ex, RegWrite_ex, Branch_ex;
  logic [4:0]  towrite_ex;
  logic [1:0]  load_byte;
  logic        store_byte_in;

  int n_chk  = 0;
  int n_pass = 0;

  ex_stage dut (
    .clk(clk), .reset(reset), .valid_id(valid_id), .opA(opA), .opB(opB),
    .st_data(st_data), .alu_op(alu_op), .mem_rd_id(mem_rd_id), .mem_wr_id(mem_wr_id),
    .MemtoReg_id(MemtoReg_id), .RegWrite_id(RegWrite_id), .Branch_id(Branch_id),
    .towrite_id(towrite_id), .load_byte_id(load_byte_id), .store_byte_id(store_byte_id),
    .flush(flush), .stall_out(stall_out), .addr(addr), .din(din), .cs(cs), .oe(oe),
    .we(we), .MemtoReg_ex(MemtoReg_ex), .RegWrite_ex(RegWrite_ex), .Branch_ex(Branch_ex),
    .towrite_ex(towrite_ex), .load_byte(load_byte), .store_byte_in(store_byte_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    valid_id = 0; opA = 0; opB = 0; st_data = 0; alu_op = 0;
    mem_rd_id = 0; mem_wr_id = 0; MemtoReg_id = 0; RegWrite_id = 0; Branch_id = 0;
    towrite_id = 0; load_byte_id = 0; store_byte_id = 0; flush = 0;
  endtask

  task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input string tag);
    clear_in();
    valid_id = 1; alu_op = op; opA = a; opB = b;
    #1 chk({tag, "_stall"}, stall_out, 0);
    step();
    chk(tag, addr, exp);
  endtask

  // MUL presented in T: stall T..T+31, bubbles T+1..T+32, result in T+33
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
    clear_in();
    valid_id = 1; alu_op = 4'd13; opA = a; opB = b; RegWrite_id = 1; towrite_id = 5;
    #1 chk({tag, "_stall_T"}, stall_out, 1);
    for (int k = 1; k <= 32; k++) begin
      step();
      chk({tag, "_stall_busy"}, stall_out, (k <= 31) ? 1 : 0);
      chk({tag, "_bubble_addr"}, addr, 0);
      chk({tag, "_bubble_rw"}, RegWrite_ex, 0);
      if (k == 32) valid_id = 0;
    end
    step();
    chk({tag, "_result"}, addr, exp);
    chk({tag, "_rw"}, RegWrite_ex, 1);
    chk({tag, "_tw"}, towrite_ex, 5);
    chk({tag, "_stall_after"}, stall_out, 0);
  endtask

  initial begin
    clear_in();
    reset = 1;
    valid_id = 1; alu_op = 4'd13; opA = 3; opB = 4;
    #12;
    chk("rst_addr", addr, 0);
    chk("rst_cs", cs, 0);
    chk("rst_rw", RegWrite_ex, 0);
    chk("rst_tw", towrite_ex, 0);
    chk("rst_stall", stall_out, 0);
    clear_in();
    reset = 0;
    step();

    clear_in();
    valid_id = 1; alu_op = 0; opA = 32'h7FFF_FFFF; opB = 1; RegWrite_id = 1; towrite_id = 3;
    #1 chk("add_stall", stall_out, 0);
    step();
    chk("add_addr", addr, 32'h8000_0000);
    chk("add_rw", RegWrite_ex, 1);
    chk("add_tw", towrite_ex, 3);
    chk("add_stall_next", stall_out, 0);

    alu(4'd7,  32'h8000_0010, 32'd4, 32'hF800_0001, "sra");
    alu(4'd8,  32'hFFFF_FFFF, 32'd1, 32'd1, "slt");
    alu(4'd9,  32'hFFFF_FFFF, 32'd1, 32'd0, "sltu");
    alu(4'd12, 32'd0, 32'h0000_1234, 32'h1234_0000, "lhi");
    alu(4'd1,  32'd5, 32'd7, 32'hFFFF_FFFE, "sub");
    alu(4'd15, 32'd2, 32'd3, 32'd5, "op15_add");
    alu(4'd10, 32'd9, 32'd9, 32'd1, "seq");

    clear_in();
    valid_id = 1; opA = 32'h100; opB = 8; mem_wr_id = 1; st_data = 32'hDEAD_BEEF; store_byte_id = 1;
    step();
    chk("st_addr", addr, 32'h108);
    chk("st_din", din, 32'hDEAD_BEEF);
    chk("st_cs", cs, 1);
    chk("st_we", we, 1);
    chk("st_oe", oe, 0);
    chk("st_sb", store_byte_in, 1);

    clear_in();
    valid_id = 1; opA = 4; opB = 4; RegWrite_id = 1; towrite_id = 0;
    mem_rd_id = 1; MemtoReg_id = 1; load_byte_id = 2'b10;
    step();
    chk("r0_rw", RegWrite_ex, 0);
    chk("ld_oe", oe, 1);
    chk("ld_cs", cs, 1);
    chk("ld_m2r", MemtoReg_ex, 1);
    chk("ld_lb", load_byte, 2'b10);

    valid_id = 0;
    step();
    chk("bub_addr", addr, 0);
    chk("bub_cs", cs, 0);
    chk("bub_m2r", MemtoReg_ex, 0);

    run_mul(32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, "mul_a");
    run_mul(32'd12345, 32'd6789, 32'd83810205, "mul_b");

    clear_in();
    valid_id = 1; alu_op = 4'd13; opA = 5; opB = 5; RegWrite_id = 1; towrite_id = 6;
    for (int k = 1; k <= 10; k++) step();
    flush = 1;
    #1 chk("fl_stall", stall_out, 0);
    step();
    clear_in();
    chk("fl_bubble", addr, 0);
    valid_id = 1; opA = 32'h10; opB = 32'h20; RegWrite_id = 1; towrite_id = 4;
    #1 chk("fl_add_stall", stall_out, 0);
    step();
    chk("fl_add_addr", addr, 32'h30);
    chk("fl_add_rw", RegWrite_ex, 1);
    valid_id = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      chk("fl_no_result", addr, 0);
      chk("fl_idle_stall", stall_out, 0);
    end

    clear_in();
    valid_id = 1; alu_op = 4'd13; opA = 9; opB = 9; RegWrite_id = 1; towrite_id = 7;
    for (int k = 1; k <= 5; k++) step();
    #2 reset = 1;
    #1;
    chk("mr_addr", addr, 0);
    chk("mr_rw", RegWrite_ex, 0);
    chk("mr_stall", stall_out, 0);
    step();
    step();
    clear_in();
    #2 reset = 0;
    #1;
    chk("mr_rel_stall", stall_out, 0);
    chk("mr_rel_addr", addr, 0);
    run_mul(32'd7, 32'd6, 32'd42, "mul_c");

    clear_in();
    valid_id = 1; opA = 1; opB = 1; RegWrite_id = 1; towrite_id = 2;
    step();
    chk("ar_pre", addr, 2);
    #2 reset = 1;
    #1;
    chk("ar_addr", addr, 0);
    chk("ar_rw", RegWrite_ex, 0);
    chk("ar_tw", towrite_ex, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage. Sits between decode and `Mem_stage`, and registers everything `Mem_stage` consumes: address/ALU result, store data, SRAM strobes, writeback controls, byte-mode controls and the branch flag.
- Single-cycle ALU for all ops except MUL. MUL uses a 32-step iterative shift-add unit that stalls decode while it runs.
- Also provides flush (squash) handling for taken branches.

Parameters:
- DATA_W, 32, datapath width. Mult step count equals DATA_W.
- REG_AW, 5, register-specifier width.

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state
- valid_id  in  1  decode presents an instruction this cycle
- opA  in  32  operand A (rs)
- opB  in  32  operand B (rt or sign-extended immediate)
- st_data  in  32  store data
- alu_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 SEQ, 11 SNE, 12 LHI, 13 MUL; 14-15 decode as ADD
- mem_rd_id, mem_wr_id  in  1 each  load / store
- MemtoReg_id, RegWrite_id, Branch_id  in  1 each  control passthrough
- towrite_id  in  5  destination register
- load_byte_id  in  2  10 = LBU, 01 = LB, else word
- store_byte_id  in  1  byte store
- flush  in  1  squash the instruction in EX and abort any MUL
- stall_out  out  1  decode must hold its inputs
- addr  out  32  ALU result / memory address
- din  out  32  store data
- cs, oe, we  out  1 each  SRAM strobes
- MemtoReg_ex, RegWrite_ex, Branch_ex  out  1 each
- towrite_ex  out  5
- load_byte  out  2
- store_byte_in  out  1

Behaviour:
- All outputs are registered.
- Reset values: every output 0, FSM IDLE, mult counter 0, accumulator 0. `stall_out` is 0 during reset.
- Bubble = all outputs 0.
- Non-MUL op, IDLE, `valid_id`=1, `flush`=0: result is visible one cycle after presentation.
  - `addr` = ALU result.
  - `din` = `st_data`.
  - `cs` = `mem_rd_id | mem_wr_id`; `oe` = `mem_rd_id`; `we` = `mem_wr_id`.
  - Remaining controls copied.
- `valid_id`=0: bubble captured.
- `RegWrite_ex` is forced 0 when `towrite_id` = 0 (r0 never written).
- ALU width rules: 32-bit wrap-around for ADD/SUB.
  - Shifts use `opB[4:0]`.
  - SLT signed, SLTU unsigned; SLT/SLTU/SEQ/SNE produce 0 or 1.
  - LHI = `opB` << 16.
  - MUL = low 32 bits of the product (identical for signed and unsigned).
- FSM states: IDLE, MUL_BUSY.
  - IDLE → MUL_BUSY on `valid_id` & `alu_op`=13 & ~`flush`.
    - Latch multiplicand = `opA`, multiplier = `opB`, all controls; acc = 0, cnt = 0.
    - Output register takes a bubble.
  - MUL_BUSY, each edge:
    - if multiplier[0], acc += multiplicand;
    - multiplicand <<= 1; multiplier >>= 1; cnt++.
    - Output takes a bubble, except when cnt = 31.
  - At cnt = 31: the final sum is written to `addr` together with the latched controls; `din`/strobes come from the latched values; state → IDLE.
- `stall_out` = (IDLE & `valid_id` & `alu_op`=13 & ~`flush`) | (MUL_BUSY & cnt≠31).
  - For MUL presented in cycle T: stall is high T..T+31 (32 cycles) and low in T+32, so decode advances on that same edge.
  - Result is visible in T+33.
  - A back-to-back MUL presented in T+33 starts normally.
- `flush` (sampled at posedge) has highest priority:
  - output register takes a bubble, state → IDLE, cnt → 0;
  - the incoming instruction is discarded;
  - `stall_out` is 0 combinationally while `flush`=1.
- Reset asserted mid-MUL aborts it immediately; outputs go to 0 asynchronously.
- Inputs are ignored while MUL_BUSY; decode is stalled.

Test Plan:
- ADD 0x7FFFFFFF+1, RegWrite, towrite=3 → next cycle `addr`=0x80000000, `RegWrite_ex`=1, `towrite_ex`=3, `stall_out` never high.
- SRA `opA`=0x80000010, `opB`=4 → `addr`=0xF8000001. SLT −1 vs 1 → 1; SLTU same operands → 0. LHI `opB`=0x1234 → 0x12340000.
- Store: ADD base 0x100 + 8, `mem_wr_id`=1, `st_data`=0xDEADBEEF, `store_byte_id`=1 → `addr`=0x108, `din`=0xDEADBEEF, `cs`=1, `we`=1, `oe`=0, `store_byte_in`=1. ADD with towrite=0, RegWrite=1 → `RegWrite_ex`=0.
- MUL 0xFFFFFFFF×3 at cycle T → `stall_out` high T..T+31, bubbles on outputs T+1..T+32, `addr`=0xFFFFFFFD at T+33. Repeat with 12345×6789 → 83810205.
- MUL at T, `flush` at T+10 → bubble at T+11, `stall_out`=0 from T+10, no result ever emitted; a following ADD completes in 1 cycle.
- Reset asserted mid-MUL (T+5), released at T+7 → all outputs 0 immediately, IDLE, `stall_out`=0; a new MUL 7×6 yields 42 after 33 cycles.
